spi_frame_ctrl: RTL and testbench
=================================

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles allowed between SS fall or last byte and the next byte inside a frame.
REQ-002 Parameter DEBOUNCE_N, default 3: consecutive touched frames required before touch_active asserts; legal range 1..15.
REQ-003 Port clk  input  1  system clock; reset rst, synchronous, active-high; clock clk.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port ss_n  input  1  raw SPI slave select, active-low, asynchronous to clk.
REQ-006 Port rx_valid  input  1  one-clk pulse from the byte interface: byte received.
REQ-007 Port rx  input  8  received byte; valid when rx_valid=1.
REQ-008 Port tx  output  8  reply byte the byte interface shifts out next.
REQ-009 Port x  output  12  committed X coordinate.
REQ-010 Port y  output  12  committed Y coordinate.
REQ-011 Port touched  output  8  committed touch byte.
REQ-012 Port sample_valid  output  1  one-clk pulse when x/y/touched update.
REQ-013 Port touch_active  output  1  debounced touch flag.
REQ-014 Port frame_err_cnt  output  8  saturating count of errored frames.

Function
REQ-015 ss_n SHALL pass through a 2-flop synchronizer; ss_s is the synchronized value; all edge detection SHALL use ss_s.
REQ-016 The FSM SHALL have states IDLE, RECV, COMMIT, WAIT_END and ERROR.
REQ-017 IDLE -> RECV on ss_s falling edge: clear byte_cnt and the timer, and latch reply = {0xA5, seq, frame_err_cnt, {touch_active, last_err[1:0], 5'b0}}.
REQ-018 In IDLE, rx_valid SHALL be ignored.
REQ-019 In RECV, rx_valid SHALL store rx into slot byte_cnt, increment byte_cnt and clear the timer.
REQ-020 Frame layout: byte0=touched, byte1=y[7:0], byte2={x[3:0],y[11:8]}, byte3=x[11:4].
REQ-021 RECV -> COMMIT on the 4th rx_valid.
REQ-022 In COMMIT, the block SHALL update x/y/touched, pulse sample_valid, increment seq (8-bit, wraps 255->0) and the debounce logic, then go to WAIT_END.
REQ-023 Latency: sample_valid SHALL assert exactly 2 clk after the 4th rx_valid.
REQ-024 RECV with ss_s rising edge and byte_cnt=0 SHALL go to IDLE with no error.
REQ-025 RECV with ss_s rising edge and byte_cnt 1..3 SHALL record a short-frame error (last_err=01) and go to IDLE.
REQ-026 RECV with timer = TIMEOUT_CYCLES SHALL record a timeout error (last_err=10) and go to ERROR.
REQ-027 WAIT_END with rx_valid SHALL record an overrun error (last_err=11) and go to ERROR; committed data SHALL be kept.
REQ-028 WAIT_END -> IDLE on ss_s rising edge.
REQ-029 ERROR SHALL ignore all bytes and go to IDLE on ss_s rising edge.
REQ-030 frame_err_cnt SHALL increment by 1 per recorded error and saturate at 255.
REQ-031 A frame SHALL record at most one error.
REQ-032 rx_valid and an ss_s rising edge in the same cycle: the byte SHALL be processed first, then the edge. A 4th byte in that cycle SHALL commit and then end in IDLE via WAIT_END.
REQ-033 tx SHALL be registered and equal reply[byte_cnt], updated the cycle after the SS fall or rx_valid.
REQ-034 tx SHALL be 0xA5 in IDLE and 0x00 in WAIT_END and ERROR.
REQ-035 Debounce, committed touched!=0: a 4-bit counter increments, saturating at DEBOUNCE_N; touch_active=1 when the counter equals DEBOUNCE_N.
REQ-036 Debounce, committed touched==0: the counter SHALL clear and touch_active SHALL deassert in the same cycle sample_valid pulses.
REQ-037 Errored frames SHALL NOT affect the debounce counter.

Reset
REQ-038 rst SHALL force IDLE and clear byte_cnt, timer, seq, debounce counter, last_err, x, y, touched, sample_valid, touch_active and frame_err_cnt to 0, and set tx=0xA5.
REQ-039 rst mid-frame SHALL discard partial bytes, record no error, and treat the next ss_s fall as a new frame; the synchronizer resets to 1.

Verification
REQ-040 Scenario: SS low, bytes 01,34,52,A6, SS high -> x=0xA65, y=0x234, touched=0x01, sample_valid 1 pulse, seq=1.
REQ-041 Scenario: SS low, 2 bytes, SS high -> no sample_valid, frame_err_cnt=1, next reply byte2=0x01, last_err=01.
REQ-042 Scenario: SS low, 1 byte, then no activity for TIMEOUT_CYCLES -> ERROR, frame_err_cnt=1; further bytes ignored until SS high.
REQ-043 Scenario: 3 frames touched=0x01 -> touch_active rises on the 3rd sample_valid; a 4th frame with touched=0x00 -> touch_active falls with that pulse.
REQ-044 Scenario: 5 bytes in one SS window -> first 4 committed, overrun error, frame_err_cnt+1; 300 short frames -> frame_err_cnt holds at 255.
REQ-045 Scenario: rst asserted after 2 bytes -> all outputs 0, tx=0xA5; a following full frame commits normally with seq=1.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl
// Frames 4-byte touch-controller reports received over an SPI byte interface.
// Each frame opens on a falling edge of the synchronized slave-select and
// carries a fixed report: touched, y[7:0], {x[3:0], y[11:8]}, x[11:4].
// Complete frames are committed to the x/y/touched outputs. Short frames,
// timeouts and overruns are counted as errors. While a frame is received,
// a 4-byte status reply is shifted back: {0xA5, seq, err count, flags}.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   ss_n              raw slave select (active-low, asynchronous to clk)
//   rx_valid, rx      one-clk byte strobe and received byte
//   tx                reply byte the byte interface shifts out next
//   x, y, touched     committed coordinates and touch byte
//   sample_valid      one-clk pulse when x/y/touched update
//   touch_active      debounced touch flag
//   frame_err_cnt     saturating count of errored frames
module spi_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DEBOUNCE_N     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx,
    output logic [7:0]  tx,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  touched,
    output logic        sample_valid,
    output logic        touch_active,
    output logic [7:0]  frame_err_cnt
);
    localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    DB_MAX      = 4'(DEBOUNCE_N);

    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {IDLE, RECV, COMMIT, WAIT_END, ERROR} state_t;

    state_t        state_q, state_d;
    logic          ss_meta_q, ss_s_q, ss_prev_q;
    logic          ss_fall, ss_rise;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   reply_q, reply_d;
    logic [7:0]    tx_q, tx_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [7:0]    touched_q, touched_d;
    logic          sample_valid_q, sample_valid_d;
    logic          touch_active_q, touch_active_d;
    logic [3:0]    db_cnt_q, db_cnt_d;
    logic [7:0]    seq_q, seq_d;
    logic [1:0]    last_err_q, last_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          end_pend_q, end_pend_d;
    logic          err_set;
    logic [1:0]    err_code;
    logic          buf_we;
    logic [7:0]    buf_q [4];
    logic [1:0]    next_slot;
    logic [7:0]    reply_next_byte;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta_q <= 1'b1;
            ss_s_q    <= 1'b1;
            ss_prev_q <= 1'b1;
        end else begin
            ss_meta_q <= ss_n;
            ss_s_q    <= ss_meta_q;
            ss_prev_q <= ss_s_q;
        end
    end

    assign ss_fall = ss_prev_q & ~ss_s_q;
    assign ss_rise = ~ss_prev_q & ss_s_q;

    // Byte slots: plain storage, no reset needed; a partial frame is simply
    // overwritten by the next one.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[byte_cnt_q[1:0]] <= rx;
        end
    end

    // Reply byte that goes out after the byte currently being received.
    assign next_slot = byte_cnt_q[1:0] + 2'd1;
    always_comb begin
        case (next_slot)
            2'd1:    reply_next_byte = reply_q[23:16];
            2'd2:    reply_next_byte = reply_q[15:8];
            2'd3:    reply_next_byte = reply_q[7:0];
            default: reply_next_byte = reply_q[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            byte_cnt_q     <= 3'd0;
            timer_q        <= '0;
            reply_q        <= 32'd0;
            tx_q           <= 8'hA5;
            x_q            <= 12'd0;
            y_q            <= 12'd0;
            touched_q      <= 8'd0;
            sample_valid_q <= 1'b0;
            touch_active_q <= 1'b0;
            db_cnt_q       <= 4'd0;
            seq_q          <= 8'd0;
            last_err_q     <= 2'b00;
            err_cnt_q      <= 8'd0;
            end_pend_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            timer_q        <= timer_d;
            reply_q        <= reply_d;
            tx_q           <= tx_d;
            x_q            <= x_d;
            y_q            <= y_d;
            touched_q      <= touched_d;
            sample_valid_q <= sample_valid_d;
            touch_active_q <= touch_active_d;
            db_cnt_q       <= db_cnt_d;
            seq_q          <= seq_d;
            last_err_q     <= last_err_d;
            err_cnt_q      <= err_cnt_d;
            end_pend_q     <= end_pend_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        timer_d        = timer_q;
        reply_d        = reply_q;
        tx_d           = tx_q;
        x_d            = x_q;
        y_d            = y_q;
        touched_d      = touched_q;
        sample_valid_d = 1'b0;
        touch_active_d = touch_active_q;
        db_cnt_d       = db_cnt_q;
        seq_d          = seq_q;
        last_err_d     = last_err_q;
        err_cnt_d      = err_cnt_q;
        end_pend_d     = end_pend_q;
        err_set        = 1'b0;
        err_code       = 2'b00;
        buf_we         = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 8'hA5;
                if (ss_fall) begin
                    state_d    = RECV;
                    byte_cnt_d = 3'd0;
                    timer_d    = '0;
                    end_pend_d = 1'b0;
                    reply_d    = {8'hA5, seq_q, err_cnt_q,
                                  touch_active_q, last_err_q, 5'b0};
                end
            end
            RECV: begin
                // A byte is handled before an SS rise in the same cycle.
                if (rx_valid) begin
                    buf_we     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    timer_d    = '0;
                    if (byte_cnt_q == 3'd3) begin
                        state_d    = COMMIT;
                        tx_d       = 8'h00;
                        // Remember a coincident SS rise so WAIT_END can exit.
                        end_pend_d = ss_rise;
                    end else if (ss_rise) begin
                        err_set  = 1'b1;
                        err_code = ERR_SHORT;
                        state_d  = IDLE;
                        tx_d     = 8'hA5;
                    end else begin
                        tx_d = reply_next_byte;
                    end
                end else if (ss_rise) begin
                    state_d = IDLE;
                    tx_d    = 8'hA5;
                    if (byte_cnt_q != 3'd0) begin
                        err_set  = 1'b1;
                        err_code = ERR_SHORT;
                    end
                end else if (timer_q == TIMEOUT_VAL) begin
                    err_set  = 1'b1;
                    err_code = ERR_TIMEOUT;
                    state_d  = ERROR;
                    tx_d     = 8'h00;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMMIT: begin
                touched_d      = buf_q[0];
                y_d            = {buf_q[2][3:0], buf_q[1]};
                x_d            = {buf_q[3], buf_q[2][7:4]};
                sample_valid_d = 1'b1;
                seq_d          = seq_q + 8'd1;
                if (buf_q[0] != 8'd0) begin
                    db_cnt_d = (db_cnt_q >= DB_MAX) ? DB_MAX : db_cnt_q + 4'd1;
                end else begin
                    db_cnt_d = 4'd0;
                end
                touch_active_d = (db_cnt_d == DB_MAX);
                tx_d           = 8'h00;
                end_pend_d     = end_pend_q | ss_rise;
                state_d        = WAIT_END;
                if (rx_valid) begin
                    err_set  = 1'b1;
                    err_code = ERR_OVERRUN;
                    state_d  = (end_pend_q || ss_rise) ? IDLE : ERROR;
                end
            end
            WAIT_END: begin
                tx_d = 8'h00;
                if (rx_valid) begin
                    err_set  = 1'b1;
                    err_code = ERR_OVERRUN;
                    state_d  = (end_pend_q || ss_rise) ? IDLE : ERROR;
                end else if (end_pend_q || ss_rise) begin
                    state_d = IDLE;
                end
                if (state_d == IDLE) begin
                    tx_d = 8'hA5;
                end
            end
            ERROR: begin
                tx_d = 8'h00;
                if (ss_rise) begin
                    state_d = IDLE;
                    tx_d    = 8'hA5;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 8'hA5;
            end
        endcase

        if (err_set) begin
            last_err_d = err_code;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    assign tx            = tx_q;
    assign x             = x_q;
    assign y             = y_q;
    assign touched       = touched_q;
    assign sample_valid  = sample_valid_q;
    assign touch_active  = touch_active_q;
    assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Testbench for spi_frame_ctrl: randomized frames checked against a
// frame-level reference model of committed data, reply bytes, error count
// and touch debounce.
module tb_spi_frame_ctrl;
    localparam int TO  = 200;
    localparam int DBN = 3;

    logic        clk = 1'b0;
    logic        rst, ss_n, rx_valid;
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic [11:0] x, y;
    logic [7:0]  touched;
    logic        sample_valid, touch_active;
    logic [7:0]  frame_err_cnt;

    spi_frame_ctrl #(.TIMEOUT_CYCLES(TO), .DEBOUNCE_N(DBN)) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .rx_valid(rx_valid), .rx(rx),
        .tx(tx), .x(x), .y(y), .touched(touched),
        .sample_valid(sample_valid), .touch_active(touch_active),
        .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sample_valid monitor: counts high cycles, records timing and flag.
    int   sv_count = 0;
    int   sv_cyc = 0;
    logic sv_ta = 1'b0;
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            sv_count = sv_count + 1;
            sv_cyc   = cyc;
            sv_ta    = touch_active;
        end
    end

    // Reference model state
    logic [11:0] m_x, m_y;
    logic [7:0]  m_t, m_seq, m_err;
    logic [1:0]  m_le;
    int          m_db;
    logic        m_act;

    logic [7:0] fb [8];
    logic [7:0] obs_tx [9];
    logic [7:0] exp_reply [4];
    int         last_rx_cyc;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_t = 0; m_seq = 0; m_err = 0; m_le = 0; m_db = 0; m_act = 0;
    endtask

    task automatic model_error(input logic [1:0] code);
        if (m_err != 8'd255) m_err = m_err + 8'd1;
        m_le = code;
    endtask

    task automatic model_commit(input logic [7:0] b0, b1, b2, b3);
        m_t   = b0;
        m_y   = {b2[3:0], b1};
        m_x   = {b3, b2[7:4]};
        m_seq = m_seq + 8'd1;
        if (b0 != 8'd0) begin
            if (m_db < DBN) m_db = m_db + 1;
        end else begin
            m_db = 0;
        end
        m_act = (m_db == DBN);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx = b; rx_valid = 1'b1; last_rx_cyc = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx = 8'($urandom);
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
    endtask

    // One SS window of nb bytes; end_same raises SS so its synchronized
    // edge coincides with the last byte. Model updated at frame level.
    task automatic do_frame(input int nb, input bit end_same);
        exp_reply[0] = 8'hA5;
        exp_reply[1] = m_seq;
        exp_reply[2] = m_err;
        exp_reply[3] = {m_act, m_le, 5'b0};
        @(posedge clk); #1 ss_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 obs_tx[0] = tx;
        for (int i = 0; i < nb; i++) begin
            if (end_same && i == nb - 1) begin
                @(posedge clk); #1 ss_n = 1'b1;
                @(posedge clk);
            end
            send_byte(fb[i]);
            obs_tx[i+1] = tx;
            if (!(end_same && i == nb - 1)) repeat ($urandom_range(2, 3)) @(posedge clk);
        end
        if (!end_same) begin
            @(posedge clk); #1 ss_n = 1'b1;
        end
        repeat (6) @(posedge clk);
        #1;
        if (nb >= 4) model_commit(fb[0], fb[1], fb[2], fb[3]);
        if (nb > 4) model_error(2'b11);
        else if (nb >= 1 && nb <= 3) model_error(2'b01);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (x !== 12'd0) begin failures++; $display("FAIL reset_x got=%h exp=000", x); end
        checks++; if (y !== 12'd0) begin failures++; $display("FAIL reset_y got=%h exp=000", y); end
        checks++; if (touched !== 8'd0) begin failures++; $display("FAIL reset_touched got=%h exp=00", touched); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sv got=%b exp=0", sample_valid); end
        checks++; if (touch_active !== 1'b0) begin failures++; $display("FAIL reset_ta got=%b exp=0", touch_active); end
        checks++; if (frame_err_cnt !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", frame_err_cnt); end
        checks++; if (tx !== 8'hA5) begin failures++; $display("FAIL reset_tx got=%h exp=a5", tx); end
        $display("reset: outputs x=%h y=%h touched=%h tx=%h", x, y, touched, tx);
    endtask

    task automatic test_basic();
        int sv0;
        sv0 = sv_count;
        fb[0] = 8'h01; fb[1] = 8'h34; fb[2] = 8'h52; fb[3] = 8'hA6;
        do_frame(4, 1'b0);
        checks++; if (x !== m_x) begin failures++; $display("FAIL basic_x got=%h exp=%h", x, m_x); end
        checks++; if (y !== m_y) begin failures++; $display("FAIL basic_y got=%h exp=%h", y, m_y); end
        checks++; if (touched !== m_t) begin failures++; $display("FAIL basic_touched got=%h exp=%h", touched, m_t); end
        checks++; if (sv_count !== sv0 + 1) begin failures++; $display("FAIL basic_sv_pulses got=%0d exp=%0d", sv_count - sv0, 1); end
        checks++; if (sv_cyc - last_rx_cyc !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", sv_cyc - last_rx_cyc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_tx[k] !== exp_reply[k]) begin failures++; $display("FAIL basic_tx%0d got=%h exp=%h", k, obs_tx[k], exp_reply[k]); end
        end
        checks++; if (tx !== 8'hA5) begin failures++; $display("FAIL basic_idle_tx got=%h exp=a5", tx); end
        $display("basic: x=%h y=%h touched=%h seq_model=%0d", x, y, touched, m_seq);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            rand_bytes();
            do_frame(4, 1'b0);
            checks++; if ({x, y, touched} !== {m_x, m_y, m_t}) begin failures++; $display("FAIL rand_data got=%h/%h/%h exp=%h/%h/%h", x, y, touched, m_x, m_y, m_t); end
            checks++; if (obs_tx[1] !== exp_reply[1]) begin failures++; $display("FAIL rand_seq got=%h exp=%h", obs_tx[1], exp_reply[1]); end
            checks++; if (obs_tx[3] !== exp_reply[3]) begin failures++; $display("FAIL rand_flags got=%h exp=%h", obs_tx[3], exp_reply[3]); end
            $display("random frame %0d: bytes=%h %h %h %h x=%h y=%h", f, fb[0], fb[1], fb[2], fb[3], x, y);
        end
    endtask

    task automatic test_short();
        int sv0;
        sv0 = sv_count;
        rand_bytes();
        do_frame(2, 1'b0);
        checks++; if (sv_count !== sv0) begin failures++; $display("FAIL short_no_sv got=%0d exp=0", sv_count - sv0); end
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL short_errcnt got=%0d exp=%0d", frame_err_cnt, m_err); end
        checks++; if (x !== m_x) begin failures++; $display("FAIL short_keep_x got=%h exp=%h", x, m_x); end
        rand_bytes();
        do_frame(4, 1'b0);
        checks++; if (obs_tx[2] !== exp_reply[2]) begin failures++; $display("FAIL short_reply_cnt got=%h exp=%h", obs_tx[2], exp_reply[2]); end
        checks++; if (obs_tx[3] !== exp_reply[3]) begin failures++; $display("FAIL short_reply_flags got=%h exp=%h", obs_tx[3], exp_reply[3]); end
        $display("short: errcnt=%0d next reply cnt=%h flags=%h", frame_err_cnt, obs_tx[2], obs_tx[3]);
    endtask

    task automatic test_timeout();
        int sv0;
        logic [7:0] err0;
        err0 = m_err;
        @(posedge clk); #1 ss_n = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'($urandom));
        repeat (TO - 3) @(posedge clk);
        #1;
        checks++; if (frame_err_cnt !== err0) begin failures++; $display("FAIL timeout_early got=%0d exp=%0d", frame_err_cnt, err0); end
        repeat (6) @(posedge clk);
        #1;
        model_error(2'b10);
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL timeout_errcnt got=%0d exp=%0d", frame_err_cnt, m_err); end
        checks++; if (tx !== 8'h00) begin failures++; $display("FAIL timeout_tx got=%h exp=00", tx); end
        sv0 = sv_count;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom));
            repeat (2) @(posedge clk);
        end
        checks++; if (sv_count !== sv0) begin failures++; $display("FAIL timeout_ignore_sv got=%0d exp=0", sv_count - sv0); end
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL timeout_single_err got=%0d exp=%0d", frame_err_cnt, m_err); end
        @(posedge clk); #1 ss_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (tx !== 8'hA5) begin failures++; $display("FAIL timeout_idle_tx got=%h exp=a5", tx); end
        rand_bytes();
        do_frame(4, 1'b0);
        checks++; if (obs_tx[3] !== exp_reply[3]) begin failures++; $display("FAIL timeout_flags got=%h exp=%h", obs_tx[3], exp_reply[3]); end
        $display("timeout: errcnt=%0d flags=%h", frame_err_cnt, obs_tx[3]);
    endtask

    task automatic test_debounce();
        for (int f = 0; f < 6; f++) begin
            rand_bytes();
            fb[0] = (f == 0 || f == 5) ? 8'h00 : 8'($urandom_range(1, 255));
            do_frame(4, 1'b0);
            checks++; if (sv_ta !== m_act) begin failures++; $display("FAIL debounce_ta_at_pulse%0d got=%b exp=%b", f, sv_ta, m_act); end
            checks++; if (touch_active !== m_act) begin failures++; $display("FAIL debounce_ta%0d got=%b exp=%b", f, touch_active, m_act); end
            $display("debounce frame %0d: touched=%h touch_active=%b", f, fb[0], touch_active);
        end
    endtask

    task automatic test_same_cycle();
        int sv0;
        sv0 = sv_count;
        rand_bytes();
        do_frame(4, 1'b1);
        checks++; if (sv_count !== sv0 + 1) begin failures++; $display("FAIL same_sv got=%0d exp=1", sv_count - sv0); end
        checks++; if ({x, y, touched} !== {m_x, m_y, m_t}) begin failures++; $display("FAIL same_data got=%h/%h/%h exp=%h/%h/%h", x, y, touched, m_x, m_y, m_t); end
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL same_errcnt got=%0d exp=%0d", frame_err_cnt, m_err); end
        checks++; if (tx !== 8'hA5) begin failures++; $display("FAIL same_idle_tx got=%h exp=a5", tx); end
        rand_bytes();
        do_frame(3, 1'b1);
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL same_short_errcnt got=%0d exp=%0d", frame_err_cnt, m_err); end
        rand_bytes();
        do_frame(4, 1'b0);
        checks++; if (obs_tx[3] !== exp_reply[3]) begin failures++; $display("FAIL same_flags got=%h exp=%h", obs_tx[3], exp_reply[3]); end
        checks++; if (x !== m_x) begin failures++; $display("FAIL same_next_x got=%h exp=%h", x, m_x); end
        $display("same-cycle: errcnt=%0d x=%h", frame_err_cnt, x);
    endtask

    task automatic test_overrun_saturate();
        int sv0;
        sv0 = sv_count;
        rand_bytes();
        do_frame(5, 1'b0);
        checks++; if ({x, y, touched} !== {m_x, m_y, m_t}) begin failures++; $display("FAIL overrun_data got=%h/%h/%h exp=%h/%h/%h", x, y, touched, m_x, m_y, m_t); end
        checks++; if (sv_count !== sv0 + 1) begin failures++; $display("FAIL overrun_sv got=%0d exp=1", sv_count - sv0); end
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL overrun_errcnt got=%0d exp=%0d", frame_err_cnt, m_err); end
        $display("overrun: errcnt=%0d", frame_err_cnt);
        for (int f = 0; f < 300; f++) begin
            rand_bytes();
            do_frame($urandom_range(1, 3), 1'b0);
        end
        checks++; if (frame_err_cnt !== m_err) begin failures++; $display("FAIL saturate_errcnt got=%0d exp=%0d", frame_err_cnt, m_err); end
        $display("saturate: errcnt=%0d after 300 short frames", frame_err_cnt);
    endtask

    task automatic test_rst_midframe();
        int sv0;
        @(posedge clk); #1 ss_n = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        @(posedge clk); #1 rst = 1'b1; ss_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if ({x, y, touched} !== 32'd0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", x, y, touched); end
        checks++; if ({sample_valid, touch_active} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", sample_valid, touch_active); end
        checks++; if (frame_err_cnt !== 8'd0) begin failures++; $display("FAIL rst_errcnt got=%0d exp=0", frame_err_cnt); end
        checks++; if (tx !== 8'hA5) begin failures++; $display("FAIL rst_tx got=%h exp=a5", tx); end
        sv0 = sv_count;
        rand_bytes();
        do_frame(4, 1'b0);
        checks++; if (sv_count !== sv0 + 1) begin failures++; $display("FAIL rst_frame_sv got=%0d exp=1", sv_count - sv0); end
        checks++; if ({x, y, touched} !== {m_x, m_y, m_t}) begin failures++; $display("FAIL rst_frame_data got=%h/%h/%h exp=%h/%h/%h", x, y, touched, m_x, m_y, m_t); end
        rand_bytes();
        do_frame(4, 1'b0);
        checks++; if (obs_tx[1] !== exp_reply[1]) begin failures++; $display("FAIL rst_seq got=%h exp=%h", obs_tx[1], exp_reply[1]); end
        checks++; if (obs_tx[2] !== exp_reply[2]) begin failures++; $display("FAIL rst_reply_cnt got=%h exp=%h", obs_tx[2], exp_reply[2]); end
        $display("rst mid-frame: seq byte=%h errcnt=%0d", obs_tx[1], frame_err_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ss_n = 1'b1; rx_valid = 1'b0; rx = 8'h00; last_rx_cyc = 0;
        model_reset();
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_random_frames();
        test_short();
        test_timeout();
        test_debounce();
        test_same_cycle();
        test_overrun_saturate();
        test_rst_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
